hrmf_ctrl: RTL and testbench

- Sequencing controller for the 4-parallel, 64-point HRMF FFT datapath (three R4BFU stages, ROTATOR0/MTU4X4/ROTATOR1/ETU4X4/ROTATOR2).
- Tracks frame phase at each datapath stage and drives the rotator and transposer selects and the ROTATOR2 twiddle address.
- Delays valid/start-of-packet to the output and detects framing errors.
- Sits beside the datapath, fed by the same sample stream qualifiers.

---
 rtl/hrmf_pkg.sv | 25 ++
 rtl/hrmf_if.sv | 37 +++
 rtl/hrmf_dly_pipe.sv | 32 +++
 rtl/hrmf_ctrl.sv | 133 +++++++++++++
 tb/tb_hrmf_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hrmf_pkg.sv
// HRMF FFT sequencing controller: shared constants, states and bundles.
// Frame geometry and datapath latencies for the 64-point, 4-lane pipe.
package hrmf_pkg;

  localparam int FRAME_CYC = 16;
  localparam int LAT0      = 3;
  localparam int LAT       = 15;
  localparam int PHW       = 4;
  localparam int DCW       = $clog2(LAT + 1);

  localparam logic [PHW-1:0] LAST_PH = PHW'(FRAME_CYC - 1);
  localparam logic [DCW-1:0] DLAST   = DCW'(LAT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef struct packed {
    logic           valid;
    logic           sop;
    logic [PHW-1:0] phase;
    logic [1:0]     rot1;
  } pipe_t;

endpackage

// File: rtl/hrmf_if.sv
// HRMF controller bus: sample qualifiers, config and datapath selects.
// master drives the stream, slave is the controller.
interface hrmf_if;
  import hrmf_pkg::*;

  logic           IN_VALID;
  logic           IN_SOP;
  logic [3:0]     CFG_ROT0;
  logic [1:0]     CFG_ROT1;
  logic [3:0]     SEL_ROT0;
  logic [1:0]     SEL_MTU0;
  logic [1:0]     SEL_ROT1;
  logic [1:0]     SEL_MTU1;
  logic [PHW-1:0] TF_ADDR;
  logic           OUT_VALID;
  logic           OUT_SOP;
  logic           ERR;
  logic           BUSY;

  modport master (
    output IN_VALID, IN_SOP,
    output CFG_ROT0, CFG_ROT1,
    input  SEL_ROT0, SEL_MTU0,
    input  SEL_ROT1, SEL_MTU1,
    input  TF_ADDR, OUT_VALID,
    input  OUT_SOP, ERR, BUSY
  );

  modport slave (
    input  IN_VALID, IN_SOP,
    input  CFG_ROT0, CFG_ROT1,
    output SEL_ROT0, SEL_MTU0,
    output SEL_ROT1, SEL_MTU1,
    output TF_ADDR, OUT_VALID,
    output OUT_SOP, ERR, BUSY
  );
endinterface

// File: rtl/hrmf_dly_pipe.sv
// Fixed-depth shift register mirroring the datapath latency.
// mid taps the entry TAP cycles old, last the entry DEPTH cycles old.
module hrmf_dly_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 15,
  parameter int TAP   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] entry,
  output logic [W-1:0] mid,
  output logic [W-1:0] last
);

  logic [W-1:0] sr [DEPTH];

  // advance one stage every cycle; the datapath never stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= entry;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign mid  = sr[TAP-1];
  assign last = sr[DEPTH-1];

endmodule

// File: rtl/hrmf_ctrl.sv
// HRMF FFT sequencing controller: phase tracking, selects, framing.
// Input phase drives ROTATOR0/MTU4X4; delayed phase drives the rest.
import hrmf_pkg::*;

module hrmf_ctrl (
  input  logic CLK,
  input  logic RST,
  hrmf_if.slave bus
);

  logic [1:0]     state;
  logic [PHW-1:0] cnt0;
  logic [DCW-1:0] dcnt;
  logic [3:0]     rot0_q;
  logic [1:0]     rot1_q;
  logic           err_q;

  logic           sop_v;
  logic           accept;
  logic           err_c;
  logic [PHW-1:0] ph0;
  logic [3:0]     rot0_c;
  logic [1:0]     rot1_c;
  pipe_t          entry;
  pipe_t          mid;
  pipe_t          last;
  logic           unused_bits;

  // input phase, frame config and what enters the delay pipe
  always_comb begin
    sop_v  = bus.IN_VALID & bus.IN_SOP;
    ph0    = sop_v ? '0 : cnt0;
    rot0_c = bus.IN_SOP ? bus.CFG_ROT0 : rot0_q;
    rot1_c = bus.IN_SOP ? bus.CFG_ROT1 : rot1_q;
    accept = bus.IN_VALID & (bus.IN_SOP | (state == RUN));
    entry  = '0;
    if (accept) begin
      entry.valid = 1'b1;
      entry.sop   = bus.IN_SOP;
      entry.phase = ph0;
      entry.rot1  = rot1_c;
    end
  end

  // framing errors: stray sample, mid-frame gap, early SOP
  always_comb begin
    err_c = 1'b0;
    unique case (1'b1)
      !bus.IN_VALID:
        err_c = (state == RUN) && (cnt0 != '0);
      bus.IN_SOP:
        err_c = (state == RUN) && (cnt0 != '0);
      default:
        err_c = (state != RUN);
    endcase
  end

  // frame FSM, phase counter, drain counter, config latch
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt0   <= '0;
      dcnt   <= '0;
      rot0_q <= '0;
      rot1_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_c;
      if (sop_v) begin
        rot0_q <= bus.CFG_ROT0;
        rot1_q <= bus.CFG_ROT1;
      end
      case (state)
        RUN: begin
          if (bus.IN_VALID) begin
            cnt0 <= ph0 + 1'b1;
            if (ph0 == LAST_PH) begin
              state <= DRAIN;
              dcnt  <= '0;
            end
          end else if (cnt0 != '0) begin
            // the last sample went in a cycle ago
            cnt0  <= '0;
            state <= DRAIN;
            dcnt  <= DCW'(1);
          end
        end
        IDLE: begin
          if (sop_v) begin
            state <= RUN;
            cnt0  <= PHW'(1);
          end
        end
        DRAIN: begin
          if (sop_v) begin
            state <= RUN;
            cnt0  <= PHW'(1);
          end else if (dcnt == DLAST) begin
            state <= IDLE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  hrmf_dly_pipe #(
    .W     ($bits(pipe_t)),
    .DEPTH (LAT),
    .TAP   (LAT0)
  ) u_pipe (
    .clk   (CLK),
    .rst   (RST),
    .entry (entry),
    .mid   (mid),
    .last  (last)
  );

  assign unused_bits = ^{mid.sop, last.rot1};

  assign bus.SEL_ROT0  = bus.IN_VALID ? (ph0 & rot0_c) : '0;
  assign bus.SEL_MTU0  = ph0[1:0];
  assign bus.SEL_ROT1  = mid.valid ? (mid.phase[1:0] & mid.rot1) : '0;
  assign bus.SEL_MTU1  = mid.phase[3:2];
  assign bus.TF_ADDR   = last.valid ? last.phase : '0;
  assign bus.OUT_VALID = last.valid;
  assign bus.OUT_SOP   = last.sop;
  assign bus.ERR       = err_q;
  assign bus.BUSY      = (state != IDLE);

endmodule

// File: tb/tb_hrmf_ctrl.sv
// Directed bench for hrmf_ctrl: frames, back-to-back, errors, reset.
// Inputs change 1ns after the rising edge, outputs sampled on falling.
module tb_hrmf_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  hrmf_if bus();

  hrmf_ctrl dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic v, input logic s,
                     input logic [3:0] r0, input logic [1:0] r1);
    @(posedge clk);
    #1;
    bus.IN_VALID = v;
    bus.IN_SOP   = s;
    bus.CFG_ROT0 = r0;
    bus.CFG_ROT1 = r1;
    @(negedge clk);
  endtask

  function automatic logic [17:0] outs();
    return {bus.SEL_ROT0, bus.SEL_MTU0, bus.SEL_ROT1, bus.SEL_MTU1,
            bus.TF_ADDR, bus.OUT_VALID, bus.OUT_SOP, bus.ERR, bus.BUSY};
  endfunction

  task automatic test_reset();
    bus.IN_VALID = 1'b0;
    bus.IN_SOP   = 1'b0;
    bus.CFG_ROT0 = 4'h0;
    bus.CFG_ROT1 = 2'h0;
    rst = 1'b1;
    #2;
    tests++;
    if (outs() !== 18'd0) begin
      fails++;
      $display("FAIL reset_outs got %h exp 0", outs());
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (outs() !== 18'd0) begin
        fails++;
        $display("FAIL post_reset k=%0d got %h exp 0", k, outs());
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] e4;
    logic [1:0] e2;
    logic       ev;
    logic       eb;
    for (int k = 0; k < 32; k++) begin
      if (k < 16) cyc(1'b1, k == 0, 4'hF, 2'h3);
      else        cyc(1'b0, 1'b0, 4'h0, 2'h0);
      if (k < 16) begin
        e4 = 4'(k);
        tests++;
        if (bus.SEL_ROT0 !== e4) begin
          fails++;
          $display("FAIL single_rot0 k=%0d got %0d exp %0d", k, bus.SEL_ROT0, e4);
        end
        e2 = 2'(k);
        tests++;
        if (bus.SEL_MTU0 !== e2) begin
          fails++;
          $display("FAIL single_mtu0 k=%0d got %0d exp %0d", k, bus.SEL_MTU0, e2);
        end
      end
      e2 = (k >= 3 && k < 19) ? 2'(k - 3) : 2'd0;
      tests++;
      if (bus.SEL_ROT1 !== e2) begin
        fails++;
        $display("FAIL single_rot1 k=%0d got %0d exp %0d", k, bus.SEL_ROT1, e2);
      end
      e2 = (k >= 3 && k < 19) ? 2'((k - 3) / 4) : 2'd0;
      tests++;
      if (bus.SEL_MTU1 !== e2) begin
        fails++;
        $display("FAIL single_mtu1 k=%0d got %0d exp %0d", k, bus.SEL_MTU1, e2);
      end
      ev = (k >= 15 && k < 31);
      tests++;
      if (bus.OUT_VALID !== ev) begin
        fails++;
        $display("FAIL single_ovalid k=%0d got %b exp %b", k, bus.OUT_VALID, ev);
      end
      tests++;
      if (bus.OUT_SOP !== (k == 15)) begin
        fails++;
        $display("FAIL single_osop k=%0d got %b exp %b", k, bus.OUT_SOP, k == 15);
      end
      e4 = ev ? 4'(k - 15) : 4'd0;
      tests++;
      if (bus.TF_ADDR !== e4) begin
        fails++;
        $display("FAIL single_tf k=%0d got %0d exp %0d", k, bus.TF_ADDR, e4);
      end
      tests++;
      if (bus.ERR !== 1'b0) begin
        fails++;
        $display("FAIL single_err k=%0d got %b exp 0", k, bus.ERR);
      end
      if (k >= 1) begin
        eb = (k < 31);
        tests++;
        if (bus.BUSY !== eb) begin
          fails++;
          $display("FAIL single_busy k=%0d got %b exp %b", k, bus.BUSY, eb);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] cfg;
    logic [3:0] e4;
    logic       ev;
    logic       es;
    logic       eb;
    for (int k = 0; k < 48; k++) begin
      cfg = (k < 16) ? 4'h5 : 4'hA;
      if (k < 32) cyc(1'b1, (k % 16) == 0, cfg, 2'h3);
      else        cyc(1'b0, 1'b0, 4'h0, 2'h0);
      if (k < 32) begin
        e4 = 4'(k % 16) & cfg;
        tests++;
        if (bus.SEL_ROT0 !== e4) begin
          fails++;
          $display("FAIL b2b_rot0 k=%0d got %h exp %h", k, bus.SEL_ROT0, e4);
        end
      end
      ev = (k >= 15 && k < 47);
      tests++;
      if (bus.OUT_VALID !== ev) begin
        fails++;
        $display("FAIL b2b_ovalid k=%0d got %b exp %b", k, bus.OUT_VALID, ev);
      end
      es = (k == 15 || k == 31);
      tests++;
      if (bus.OUT_SOP !== es) begin
        fails++;
        $display("FAIL b2b_osop k=%0d got %b exp %b", k, bus.OUT_SOP, es);
      end
      e4 = ev ? 4'((k - 15) % 16) : 4'd0;
      tests++;
      if (bus.TF_ADDR !== e4) begin
        fails++;
        $display("FAIL b2b_tf k=%0d got %0d exp %0d", k, bus.TF_ADDR, e4);
      end
      tests++;
      if (bus.ERR !== 1'b0) begin
        fails++;
        $display("FAIL b2b_err k=%0d got %b exp 0", k, bus.ERR);
      end
      if (k >= 1) begin
        eb = (k < 47);
        tests++;
        if (bus.BUSY !== eb) begin
          fails++;
          $display("FAIL b2b_busy k=%0d got %b exp %b", k, bus.BUSY, eb);
        end
      end
    end
  endtask

  task automatic test_gap();
    logic       v;
    logic [3:0] e4;
    logic       ev;
    logic       eb;
    int         nvalid;
    nvalid = 0;
    for (int k = 0; k < 57; k++) begin
      v = (k < 6) || (k >= 25 && k < 41);
      cyc(v, k == 0 || k == 25, 4'hF, 2'h3);
      if (k < 25 && bus.OUT_VALID === 1'b1) nvalid++;
      if (k <= 6 || (k >= 25 && k < 41)) begin
        e4 = (k <= 6) ? ((k < 6) ? 4'(k) : 4'd0) : 4'(k - 25);
        tests++;
        if (bus.SEL_ROT0 !== e4) begin
          fails++;
          $display("FAIL gap_rot0 k=%0d got %0d exp %0d", k, bus.SEL_ROT0, e4);
        end
      end
      tests++;
      if (bus.ERR !== (k == 7)) begin
        fails++;
        $display("FAIL gap_err k=%0d got %b exp %b", k, bus.ERR, k == 7);
      end
      ev = (k >= 15 && k < 21) || (k >= 40 && k < 56);
      tests++;
      if (bus.OUT_VALID !== ev) begin
        fails++;
        $display("FAIL gap_ovalid k=%0d got %b exp %b", k, bus.OUT_VALID, ev);
      end
      tests++;
      if (bus.OUT_SOP !== (k == 15 || k == 40)) begin
        fails++;
        $display("FAIL gap_osop k=%0d got %b exp %b", k, bus.OUT_SOP,
                 k == 15 || k == 40);
      end
      if (k >= 1) begin
        eb = (k < 21) || (k >= 26 && k < 56);
        tests++;
        if (bus.BUSY !== eb) begin
          fails++;
          $display("FAIL gap_busy k=%0d got %b exp %b", k, bus.BUSY, eb);
        end
      end
    end
    tests++;
    if (nvalid != 6) begin
      fails++;
      $display("FAIL gap_nvalid got %0d exp 6", nvalid);
    end
  endtask

  task automatic test_sop_mid();
    logic [3:0] e4;
    logic       ev;
    logic       eb;
    for (int k = 0; k < 41; k++) begin
      cyc(k < 25, k == 0 || k == 9, 4'hF, 2'h3);
      if (k < 25) begin
        e4 = (k < 9) ? 4'(k) : 4'(k - 9);
        tests++;
        if (bus.SEL_ROT0 !== e4) begin
          fails++;
          $display("FAIL sopmid_rot0 k=%0d got %0d exp %0d", k, bus.SEL_ROT0, e4);
        end
      end
      tests++;
      if (bus.ERR !== (k == 10)) begin
        fails++;
        $display("FAIL sopmid_err k=%0d got %b exp %b", k, bus.ERR, k == 10);
      end
      ev = (k >= 15 && k < 40);
      tests++;
      if (bus.OUT_VALID !== ev) begin
        fails++;
        $display("FAIL sopmid_ovalid k=%0d got %b exp %b", k, bus.OUT_VALID, ev);
      end
      tests++;
      if (bus.OUT_SOP !== (k == 15 || k == 24)) begin
        fails++;
        $display("FAIL sopmid_osop k=%0d got %b exp %b", k, bus.OUT_SOP,
                 k == 15 || k == 24);
      end
      e4 = !ev ? 4'd0 : (k < 24) ? 4'(k - 15) : 4'(k - 24);
      tests++;
      if (bus.TF_ADDR !== e4) begin
        fails++;
        $display("FAIL sopmid_tf k=%0d got %0d exp %0d", k, bus.TF_ADDR, e4);
      end
      if (k >= 1) begin
        eb = (k < 40);
        tests++;
        if (bus.BUSY !== eb) begin
          fails++;
          $display("FAIL sopmid_busy k=%0d got %b exp %b", k, bus.BUSY, eb);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 9; k++)
      cyc(1'b1, k == 0, 4'hF, 2'h3);
    tests++;
    if (bus.SEL_ROT0 !== 4'd8 || bus.BUSY !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre got rot0=%0d busy=%b exp rot0=8 busy=1",
               bus.SEL_ROT0, bus.BUSY);
    end
    #1;
    rst = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.IN_SOP   = 1'b0;
    #1;
    tests++;
    if (outs() !== 18'd0) begin
      fails++;
      $display("FAIL rstmid_async got %h exp 0", outs());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      cyc(1'b0, 1'b0, 4'h0, 2'h0);
      tests++;
      if (bus.OUT_VALID !== 1'b0 || bus.BUSY !== 1'b0 || bus.ERR !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_after k=%0d got v=%b busy=%b err=%b exp 0 0 0",
                 k, bus.OUT_VALID, bus.BUSY, bus.ERR);
      end
    end
  endtask

  task automatic test_idle_err();
    for (int k = 0; k < 20; k++) begin
      cyc(k == 0, 1'b0, 4'hF, 2'h3);
      if (k == 0) begin
        tests++;
        if (bus.SEL_ROT0 !== 4'd0) begin
          fails++;
          $display("FAIL idleerr_rot0 got %0d exp 0", bus.SEL_ROT0);
        end
      end
      tests++;
      if (bus.ERR !== (k == 1)) begin
        fails++;
        $display("FAIL idleerr_err k=%0d got %b exp %b", k, bus.ERR, k == 1);
      end
      tests++;
      if (bus.OUT_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
        fails++;
        $display("FAIL idleerr_state k=%0d got v=%b busy=%b exp 0 0",
                 k, bus.OUT_VALID, bus.BUSY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_sop_mid();
    test_reset_mid();
    test_idle_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
